resp_id_restorer: RTL and testbench
===================================

# resp_id_restorer

Response-path counterpart of the ROB ID allocator: accepts read-response beats from the downstream slave carrying allocator-issued unique IDs. For each beat it restores the original master ID via the allocator's free/lookup port and releases the unique ID on the last beat of a burst. Restored beats are buffered and forwarded upstream to the master. Beats carrying a unique ID that is not currently outstanding are dropped and flagged.

## Interface
Parameters:
- ID_WIDTH, 4, width of original and unique IDs (unique ID space = 2**ID_WIDTH)
- DATA_WIDTH, 32, R-channel data width
- FIFO_DEPTH, 4, response buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- alloc_gnt  in  1  allocator grant observed this cycle
- alloc_uid  in  ID_WIDTH  unique ID granted this cycle (valid with alloc_gnt)
- s_rvalid  in  1  slave response beat valid
- s_rready  out  1  beat accepted when s_rvalid & s_rready
- s_rid  in  ID_WIDTH  unique ID of beat
- s_rdata  in  DATA_WIDTH  beat data
- s_rresp  in  2  beat response code
- s_rlast  in  1  last beat of burst
- unique_id_to_free  out  ID_WIDTH  lookup/free index to allocator, always = s_rid
- restored_id  in  ID_WIDTH  original ID from allocator, combinational from unique_id_to_free
- free_req  out  1  release unique_id_to_free this cycle
- m_rvalid  out  1  upstream beat valid
- m_rready  in  1  upstream ready
- m_rid  out  ID_WIDTH  restored original ID
- m_rdata  out  DATA_WIDTH
- m_rresp  out  2
- m_rlast  out  1
- err_unknown_id  out  1  one-cycle pulse: a beat with non-outstanding UID was dropped

## Operation
- Outstanding bitmap, 2**ID_WIDTH bits: bit set on alloc_gnt at alloc_uid; bit cleared on free_req at s_rid. Same-cycle set and clear of the same bit: set wins.
- accept = s_rvalid & s_rready; known = outstanding[s_rid].
- accept & known: push {restored_id, s_rdata, s_rresp, s_rlast} into the FIFO; free_req = s_rlast.
- accept & ~known: no push, free_req = 0, err_unknown_id = 1 next cycle.
- free_req is combinational, asserted in the accept cycle only; never asserted during rst.
- s_rready = ~rst & ~fifo_full. No push when full, even if a pop occurs the same cycle.
- Upstream: m_rvalid = ~fifo_empty. Head fields drive m_*. Pop on m_rvalid & m_rready. Outputs hold stable while m_rvalid & ~m_rready.
- FIFO: read/write pointers of clog2(FIFO_DEPTH) bits wrap naturally; count of clog2(FIFO_DEPTH+1) bits. Simultaneous push and pop (not full) leaves count unchanged.
- Reset: FIFO empty, pointers/count 0, bitmap cleared, err_unknown_id 0, m_rvalid 0, s_rready 0 while rst high. Reset mid-burst discards buffered beats with no free_req for them.

## Timing
- Lookup and free occur in the accept cycle (restored_id sampled same cycle).
- Latency: beat accepted at cycle N appears on m_* at N+1 at the earliest.
- Throughput: one beat per cycle sustained when m_rready is held high.
- err_unknown_id: registered, high exactly in cycle N+1 for an unknown beat accepted at N.
- alloc_gnt at cycle N makes that UID known for beats accepted from N+1. A beat for the same UID at N is unknown.

## Structure
- Shared package rob_pkg holds typedef r_beat_t (id, data, resp, last) parameterised by ID_WIDTH/DATA_WIDTH, plus the RRESP code constants (OKAY=2'b00, SLVERR=2'b10).
- One sub-module: rob_sync_fifo (synchronous FIFO of r_beat_t; push/pop/full/empty/count), instantiated once. The bitmap, accept/free logic, and error flag live in the top.

## Test plan
- alloc_gnt uid 3; restored_id model maps 3→0xA; 4-beat burst with s_rid=3 and rlast on beat 4, m_rready=1 → four m_* beats with m_rid=0xA, one cycle after each accept; free_req only with beat 4; bit 3 cleared.
- m_rready=0, FIFO_DEPTH=4, 6 beats offered → s_rready drops after 4 accepts. Release m_rready → beats drain in order with no loss or duplication, and pointers wrap.
- Beat with s_rid=5 never allocated → s_rready=1, no push, no free_req, err_unknown_id high exactly one cycle later.
- Same cycle: m_rready=1 with FIFO holding 2 beats, plus a new known accept → count stays 2; then free of uid 3 and alloc_gnt of uid 3 in the same cycle → bit 3 remains set.
- rst asserted with 3 beats buffered → next cycle m_rvalid=0, s_rready=0 while rst is high, err_unknown_id=0. After release, a beat with an old UID is flagged unknown.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared definitions for the ROB response path: default widths, the buffered
// R-beat record and the RRESP codes.
package rob_pkg;

  localparam int R_ID_WIDTH   = 4;
  localparam int R_DATA_WIDTH = 32;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic [R_ID_WIDTH-1:0]   id;
    logic [R_DATA_WIDTH-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } r_beat_t;

endpackage

// File: rtl/rob_sync_fifo.sv
// Show-ahead synchronous FIFO of R beats; the head entry is visible on dout
// whenever empty is low.
module rob_sync_fifo
  import rob_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type beat_t = r_beat_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  beat_t                      din,
  input  logic                       pop,
  output beat_t                      dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when the head leaves in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/resp_id_restorer.sv
// Restores original master IDs on read-response beats, releases unique IDs on
// the last beat of each burst and drops beats whose unique ID is not in flight.
module resp_id_restorer
  import rob_pkg::*;
#(
  parameter int ID_WIDTH   = R_ID_WIDTH,
  parameter int DATA_WIDTH = R_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_gnt,
  input  logic [ID_WIDTH-1:0]   alloc_uid,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [ID_WIDTH-1:0]   s_rid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  output logic [ID_WIDTH-1:0]   unique_id_to_free,
  input  logic [ID_WIDTH-1:0]   restored_id,
  output logic                  free_req,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [ID_WIDTH-1:0]   m_rid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [1:0]            m_rresp,
  output logic                  m_rlast,
  output logic                  err_unknown_id
);

  localparam int NUM_UIDS = 2**ID_WIDTH;
  localparam int CNT_W    = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } beat_t;

  logic [NUM_UIDS-1:0] outstanding_reg;
  logic                err_unknown_reg;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                unused_count;
  beat_t               push_beat;
  beat_t               head_beat;
  logic                accept;
  logic                known;
  logic                push;
  logic                pop;

  assign s_rready          = ~rst & ~fifo_full;
  assign accept            = s_rvalid & s_rready;
  assign known             = outstanding_reg[s_rid];
  assign push              = accept & known;
  assign free_req          = push & s_rlast;
  assign unique_id_to_free = s_rid;
  assign unused_count      = ^fifo_count;

  // One flop per unique ID; a grant overrides a release landing on the same bit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_UIDS; gi++) begin : g_outstanding
      always_ff @(posedge clk) begin
        if (rst) begin
          outstanding_reg[gi] <= 1'b0;
        end else if (alloc_gnt && (alloc_uid == ID_WIDTH'(gi))) begin
          outstanding_reg[gi] <= 1'b1;
        end else if (free_req && (s_rid == ID_WIDTH'(gi))) begin
          outstanding_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      err_unknown_reg <= 1'b0;
    end else begin
      err_unknown_reg <= accept & ~known;
    end
  end

  assign err_unknown_id = err_unknown_reg;

  assign push_beat = '{id: restored_id, data: s_rdata, resp: s_rresp, last: s_rlast};
  assign pop       = m_rvalid & m_rready;

  rob_sync_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .beat_t (beat_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head_beat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_rvalid = ~fifo_empty;
  assign m_rid    = head_beat.id;
  assign m_rdata  = head_beat.data;
  assign m_rresp  = head_beat.resp;
  assign m_rlast  = head_beat.last;

endmodule

// File: tb/tb_resp_id_restorer.sv
// Bench for resp_id_restorer: directed scenarios then random traffic, all
// checked against a queue/array reference model of the response path.
module tb_resp_id_restorer;
  import rob_pkg::*;

  localparam int IW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_gnt;
  logic [IW-1:0] alloc_uid;
  logic          s_rvalid;
  logic          s_rready;
  logic [IW-1:0] s_rid;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast;
  logic [IW-1:0] unique_id_to_free;
  logic [IW-1:0] restored_id;
  logic          free_req;
  logic          m_rvalid;
  logic          m_rready;
  logic [IW-1:0] m_rid;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          err_unknown_id;

  always #5 clk = ~clk;

  resp_id_restorer #(
    .ID_WIDTH   (IW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .alloc_gnt         (alloc_gnt),
    .alloc_uid         (alloc_uid),
    .s_rvalid          (s_rvalid),
    .s_rready          (s_rready),
    .s_rid             (s_rid),
    .s_rdata           (s_rdata),
    .s_rresp           (s_rresp),
    .s_rlast           (s_rlast),
    .unique_id_to_free (unique_id_to_free),
    .restored_id       (restored_id),
    .free_req          (free_req),
    .m_rvalid          (m_rvalid),
    .m_rready          (m_rready),
    .m_rid             (m_rid),
    .m_rdata           (m_rdata),
    .m_rresp           (m_rresp),
    .m_rlast           (m_rlast),
    .err_unknown_id    (err_unknown_id)
  );

  // Allocator lookup table: uid 3 maps to original ID 0xA.
  logic [IW-1:0] id_map [16];
  assign restored_id = id_map[unique_id_to_free];

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } exp_beat_t;

  exp_beat_t exp_q[$];
  bit        outst[16];
  bit        err_exp;
  int        vectors     = 0;
  int        miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [IW-1:0] id, input logic [DW-1:0] d,
                       input logic [1:0] r, input bit l);
    s_rvalid = v;
    s_rid    = id;
    s_rdata  = d;
    s_rresp  = r;
    s_rlast  = l;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, OKAY, 1'b0);
    alloc_gnt = 1'b0;
    alloc_uid = '0;
  endtask

  // Check combinational/registered outputs mid-cycle, then advance the model
  // by the clock edge that follows.
  task automatic cycle();
    bit exp_rdy, exp_mv, acc, kn;
    @(negedge clk);
    exp_rdy = !rst && (exp_q.size() < DEPTH);
    exp_mv  = (exp_q.size() != 0);
    acc     = s_rvalid && exp_rdy;
    kn      = outst[s_rid];
    chk("s_rready", 64'(s_rready), 64'(exp_rdy));
    chk("m_rvalid", 64'(m_rvalid), 64'(exp_mv));
    chk("free_req", 64'(free_req), 64'(acc && kn && s_rlast));
    chk("err_unknown_id", 64'(err_unknown_id), 64'(err_exp));
    chk("unique_id_to_free", 64'(unique_id_to_free), 64'(s_rid));
    if (exp_mv) begin
      chk("m_rid", 64'(m_rid), 64'(exp_q[0].id));
      chk("m_rdata", 64'(m_rdata), 64'(exp_q[0].data));
      chk("m_rresp", 64'(m_rresp), 64'(exp_q[0].resp));
      chk("m_rlast", 64'(m_rlast), 64'(exp_q[0].last));
    end
    if (rst) begin
      exp_q.delete();
      foreach (outst[i]) outst[i] = 1'b0;
      err_exp = 1'b0;
    end else begin
      if (exp_mv && m_rready) void'(exp_q.pop_front());
      if (acc && kn) exp_q.push_back('{id_map[s_rid], s_rdata, s_rresp, s_rlast});
      err_exp = acc && !kn;
      if (acc && kn && s_rlast) outst[s_rid] = 1'b0;
      if (alloc_gnt) outst[alloc_uid] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rid;
    for (int i = 0; i < 16; i++) id_map[i] = IW'(i) ^ 4'h9;
    rst      = 1'b1;
    m_rready = 1'b0;
    idle();
    @(posedge clk);
    #1;
    foreach (outst[i]) outst[i] = 1'b0;
    err_exp = 1'b0;

    // Reset state
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Four-beat burst on uid 3, released only with the last beat
    alloc_gnt = 1'b1;
    alloc_uid = 4'd3;
    cycle();
    alloc_gnt = 1'b0;
    m_rready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd3, 32'hB000_0000 + 32'(i), OKAY, i == 3);
      cycle();
    end
    idle();
    cycle();
    // uid 3 is released now: a stray beat must be flagged
    drive(1'b1, 4'd3, 32'hDEAD_0003, OKAY, 1'b1);
    cycle();
    idle();
    cycle();

    // Backpressure: six beats offered, only four fit
    alloc_gnt = 1'b1;
    alloc_uid = 4'd1;
    cycle();
    alloc_gnt = 1'b0;
    m_rready  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'd1, 32'hC000_0000 + 32'(i), SLVERR, i == 5);
      cycle();
    end
    idle();
    m_rready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Never-allocated uid 5
    drive(1'b1, 4'd5, 32'h5555_5555, OKAY, 1'b1);
    cycle();
    idle();
    cycle();
    cycle();

    // Push and pop together with two beats held, then free/grant collide on uid 3
    alloc_gnt = 1'b1;
    alloc_uid = 4'd3;
    cycle();
    alloc_gnt = 1'b0;
    m_rready  = 1'b0;
    drive(1'b1, 4'd3, 32'hD000_0000, OKAY, 1'b0);
    cycle();
    drive(1'b1, 4'd3, 32'hD000_0001, OKAY, 1'b0);
    cycle();
    m_rready  = 1'b1;
    alloc_gnt = 1'b1;
    alloc_uid = 4'd3;
    drive(1'b1, 4'd3, 32'hD000_0002, OKAY, 1'b1);
    cycle();
    alloc_gnt = 1'b0;
    drive(1'b1, 4'd3, 32'hD000_0003, OKAY, 1'b0);
    cycle();
    idle();
    for (int i = 0; i < 4; i++) cycle();

    // Reset with three beats buffered
    m_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd3, 32'hE000_0000 + 32'(i), OKAY, 1'b0);
      cycle();
    end
    rst = 1'b1;
    drive(1'b1, 4'd3, 32'hE000_0003, OKAY, 1'b1);
    cycle();
    cycle();
    rst = 1'b0;
    m_rready = 1'b1;
    cycle();
    cycle();
    idle();
    cycle();
    cycle();

    // Random traffic, mostly on in-flight uids
    for (int n = 0; n < 500; n++) begin
      alloc_gnt = ($urandom_range(0, 3) == 0);
      alloc_uid = IW'($urandom_range(0, 15));
      rid = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 16; k++) begin
          if (outst[(rid + k) % 16]) begin
            rid = (rid + k) % 16;
            break;
          end
        end
      end
      drive($urandom_range(0, 2) != 0, rid[IW-1:0], $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0);
      m_rready = ($urandom_range(0, 2) != 0);
      rst      = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    idle();
    m_rready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
